cv32e40p_apu_arbiter: RTL and testbench
=======================================

CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 2, SHALL set the number of requesting cores sharing one APU (range 2..8).
REQ-002 Parameter ID_DEPTH, default 4, SHALL set the maximum number of outstanding APU operations (power of two, 2..16).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (clock), rst_i input 1 (synchronous reset, active-high).
REQ-004 core_req_i input [NUM_CORES] SHALL carry the per-core request; core_gnt_o output [NUM_CORES] SHALL carry the per-core grant.
REQ-005 core_operands_i input [NUM_CORES][APU_NARGS_CPU][32], core_op_i input [NUM_CORES][APU_WOP_CPU] and core_flags_i input [NUM_CORES][APU_NDSFLAGS_CPU] SHALL carry the per-core request payload.
REQ-006 core_rvalid_o output [NUM_CORES] SHALL carry the per-core response valid; core_result_o output 32 and core_flags_o output [APU_NUSFLAGS_CPU] SHALL be broadcast to all cores.
REQ-007 The APU side SHALL consist of apu_req_o out 1, apu_gnt_i in 1, apu_operands_o out [APU_NARGS_CPU][32], apu_op_o out [APU_WOP_CPU], apu_flags_o out [APU_NDSFLAGS_CPU], apu_rvalid_i in 1, apu_result_i in 32 and apu_flags_i in [APU_NUSFLAGS_CPU].
REQ-008 busy_o output 1 SHALL be high while any operation is outstanding; err_o output 1 SHALL be a sticky protocol error flag.
REQ-009 stat_grant_cnt_o output [NUM_CORES][32] SHALL carry the per-core grant counters.

Function
REQ-010 Arbitration SHALL be round-robin: the winner is the first requesting core at or after rr_ptr, in ascending index order with wrap from NUM_CORES-1 to 0.
REQ-011 apu_req_o SHALL equal OR(core_req_i) AND NOT id_full, and the winner's payload SHALL be muxed combinationally onto apu_*_o (zero latency).
REQ-012 core_gnt_o[w] SHALL equal apu_gnt_i AND apu_req_o for the winner w only; all other grant bits SHALL be 0.
REQ-013 On handshake (apu_req_o AND apu_gnt_i), rr_ptr SHALL update to (w+1) mod NUM_CORES on the next edge; with no handshake, rr_ptr SHALL hold.
REQ-014 On handshake, the winner index SHALL be pushed into the ID FIFO (depth ID_DEPTH).
REQ-015 The APU returns results in grant order; on apu_rvalid_i, the FIFO head SHALL be popped and core_rvalid_o[head] SHALL be asserted in the same cycle (combinational routing).
REQ-016 core_result_o and core_flags_o SHALL pass apu_result_i and apu_flags_i through unregistered.
REQ-017 FIFO full: apu_req_o SHALL be 0 and no grant SHALL be issued, even if a pop occurs in the same cycle.
REQ-018 Simultaneous push and pop when not full: the occupancy count SHALL remain unchanged and the pointers SHALL advance.
REQ-019 apu_rvalid_i while the FIFO is empty: the response SHALL be dropped (all core_rvalid_o = 0) and err_o SHALL be set until reset.
REQ-020 busy_o SHALL equal (count != 0).
REQ-021 A request deasserted before grant SHALL be legal; the arbiter SHALL retain no memory of it.

Reset
REQ-022 While rst_i is high at a clk_i edge, rr_ptr, the FIFO pointers, the count, err_o and the stat counters SHALL be set to 0.
REQ-023 During reset, all core_gnt_o, core_rvalid_o and apu_req_o outputs SHALL be 0.
REQ-024 A reset mid-operation SHALL discard all outstanding IDs; the APU is reset together with the arbiter, and any late response SHALL set err_o per REQ-019.

Configuration
REQ-025 With macro CV32E40P_APU_ARB_STATS_EN defined, each stat_grant_cnt_o[i] SHALL increment by 1 per handshake granted to core i, saturating at 0xFFFF_FFFF.
REQ-026 Without CV32E40P_APU_ARB_STATS_EN, stat_grant_cnt_o SHALL be tied to 0 and no counter flops SHALL be instantiated.

Structure
REQ-027 The width constants (APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU, APU_NUSFLAGS_CPU) SHALL come from cv32e40p_apu_core_pkg.
REQ-028 A new constant APU_ARB_MAX_CORES = 8 SHALL be added to cv32e40p_apu_core_pkg.
REQ-029 The ID FIFO SHALL be a sub-module, cv32e40p_apu_arb_id_fifo: $clog2(NUM_CORES)-bit data, ID_DEPTH entries, push/pop/full/empty/count ports, synchronous reset.

Verification
REQ-030 Scenario 1: core_req_i=2'b11 held, apu_gnt_i=1, apu_rvalid_i one cycle after each grant -> grants alternate 0,1,0,1 over 4 cycles and core_rvalid_o follows the same order.
REQ-031 Scenario 2: apu_gnt_i=1, apu_rvalid_i=0, core 0 requesting continuously, ID_DEPTH=4 -> exactly 4 grants, then apu_req_o=0 and busy_o=1; the first apu_rvalid_i re-enables requests on the next cycle.
REQ-032 Scenario 3: 3 outstanding IDs (1,0,1), then apu_rvalid_i with apu_result_i=0x3F80_0000 -> core_rvalid_o=2'b10 first, core_result_o=0x3F80_0000.
REQ-033 Scenario 4: apu_rvalid_i pulsed with the FIFO empty -> core_rvalid_o=0 and err_o=1, remaining 1 after 10 idle cycles until rst_i.
REQ-034 Scenario 5: rst_i asserted with 2 IDs outstanding -> next cycle busy_o=0, rr_ptr=0, and a subsequent request from core 1 alone is granted.
REQ-035 Scenario 6 (STATS_EN): 5 grants to core 0 and 3 grants to core 1 -> stat_grant_cnt_o = {3,5}; without the macro, stat_grant_cnt_o reads 0.

Source files
------------

// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU interface widths for the CV32E40P cores and the multi-core APU arbiter.
package cv32e40p_apu_core_pkg;

    localparam int unsigned APU_NARGS_CPU     = 3;
    localparam int unsigned APU_WOP_CPU       = 6;
    localparam int unsigned APU_NDSFLAGS_CPU  = 15;
    localparam int unsigned APU_NUSFLAGS_CPU  = 5;

    // Upper bound on cores that may share one APU through the arbiter
    localparam int unsigned APU_ARB_MAX_CORES = 8;

endpackage

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// In-order FIFO of granted core indices; the head names the owner of the next APU response.
module cv32e40p_apu_arb_id_fifo #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [CNT_W-1:0]             count;
    logic                         do_push;
    logic                         do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage carries no reset: stale entries are never read past the count
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU among NUM_CORES cores, routing in-order responses back by ID.
// Optional per-core grant counters are enabled with macro CV32E40P_APU_ARB_STATS_EN.
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned ID_DEPTH  = 4
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,

    input  logic [NUM_CORES-1:0]                            core_req_i,
    output logic [NUM_CORES-1:0]                            core_gnt_o,
    input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]   core_operands_i,
    input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]           core_op_i,
    input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]      core_flags_i,
    output logic [NUM_CORES-1:0]                            core_rvalid_o,
    output logic [31:0]                                     core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                     core_flags_o,

    output logic                                            apu_req_o,
    input  logic                                            apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                  apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                          apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                     apu_flags_o,
    input  logic                                            apu_rvalid_i,
    input  logic [31:0]                                     apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                     apu_flags_i,

    output logic                                            busy_o,
    output logic                                            err_o,
    output logic [NUM_CORES-1:0][31:0]                      stat_grant_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);
    localparam int unsigned CNT_W = $clog2(ID_DEPTH) + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] head;
    logic [CNT_W-1:0] id_count;
    logic             id_full;
    logic             id_empty;
    logic             handshake;
    logic             rsp_pop;

    // First requester at or after rr_ptr, wrapping past the last core
    always_comb begin
        int unsigned idx;
        logic        found;
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!found && core_req_i[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign apu_req_o      = (|core_req_i) & ~id_full & ~rst_i;
    assign handshake      = apu_req_o & apu_gnt_i;
    assign apu_operands_o = core_operands_i[winner];
    assign apu_op_o       = core_op_i[winner];
    assign apu_flags_o    = core_flags_i[winner];

    always_comb begin
        core_gnt_o = '0;
        if (handshake) begin
            core_gnt_o[winner] = 1'b1;
        end
    end

    // A response with nothing outstanding is dropped rather than misrouted
    assign rsp_pop = apu_rvalid_i & ~id_empty & ~rst_i;

    always_comb begin
        core_rvalid_o = '0;
        if (rsp_pop) begin
            core_rvalid_o[head] = 1'b1;
        end
    end

    assign core_result_o = apu_result_i;
    assign core_flags_o  = apu_flags_i;
    assign busy_o        = (id_count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (apu_rvalid_i && id_empty) begin
            err_o <= 1'b1;
        end
    end

    cv32e40p_apu_arb_id_fifo #(
        .DATA_W (IDX_W),
        .DEPTH  (ID_DEPTH)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (rsp_pop),
        .data_o  (head),
        .full_o  (id_full),
        .empty_o (id_empty),
        .count_o (id_count)
    );

`ifdef CV32E40P_APU_ARB_STATS_EN
    logic [NUM_CORES-1:0][31:0] grant_cnt;

    // Saturating per-core handshake counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (core_gnt_o[i] && (grant_cnt[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign stat_grant_cnt_o = grant_cnt;
`else
    assign stat_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Scoreboard bench for cv32e40p_apu_arbiter: directed scenarios push expected grants/responses, a monitor checks them.
module tb_cv32e40p_apu_arbiter;
    import cv32e40p_apu_core_pkg::*;

    localparam int unsigned NC  = 2;
    localparam int unsigned IDD = 4;

    logic                                     clk_i = 1'b0;
    logic                                     rst_i;
    logic [NC-1:0]                            core_req_i;
    logic [NC-1:0]                            core_gnt_o;
    logic [NC-1:0][APU_NARGS_CPU-1:0][31:0]   core_operands_i;
    logic [NC-1:0][APU_WOP_CPU-1:0]           core_op_i;
    logic [NC-1:0][APU_NDSFLAGS_CPU-1:0]      core_flags_i;
    logic [NC-1:0]                            core_rvalid_o;
    logic [31:0]                              core_result_o;
    logic [APU_NUSFLAGS_CPU-1:0]              core_flags_o;
    logic                                     apu_req_o;
    logic                                     apu_gnt_i;
    logic [APU_NARGS_CPU-1:0][31:0]           apu_operands_o;
    logic [APU_WOP_CPU-1:0]                   apu_op_o;
    logic [APU_NDSFLAGS_CPU-1:0]              apu_flags_o;
    logic                                     apu_rvalid_i;
    logic [31:0]                              apu_result_i;
    logic [APU_NUSFLAGS_CPU-1:0]              apu_flags_i;
    logic                                     busy_o;
    logic                                     err_o;
    logic [NC-1:0][31:0]                      stat_grant_cnt_o;

    typedef struct {
        logic [1:0]  gnt;
        logic [5:0]  op;
        logic [31:0] opa;
    } gnt_exp_t;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] res;
        logic [4:0]  flg;
    } rv_exp_t;

    gnt_exp_t gnt_q[$];
    rv_exp_t  rv_q[$];
    int checks = 0;
    int errors = 0;

    cv32e40p_apu_arbiter #(.NUM_CORES(NC), .ID_DEPTH(IDD)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .core_req_i       (core_req_i),
        .core_gnt_o       (core_gnt_o),
        .core_operands_i  (core_operands_i),
        .core_op_i        (core_op_i),
        .core_flags_i     (core_flags_i),
        .core_rvalid_o    (core_rvalid_o),
        .core_result_o    (core_result_o),
        .core_flags_o     (core_flags_o),
        .apu_req_o        (apu_req_o),
        .apu_gnt_i        (apu_gnt_i),
        .apu_operands_o   (apu_operands_o),
        .apu_op_o         (apu_op_o),
        .apu_flags_o      (apu_flags_o),
        .apu_rvalid_i     (apu_rvalid_i),
        .apu_result_i     (apu_result_i),
        .apu_flags_i      (apu_flags_i),
        .busy_o           (busy_o),
        .err_o            (err_o),
        .stat_grant_cnt_o (stat_grant_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        core_req_i   = '0;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b0;
        apu_result_i = '0;
        apu_flags_i  = '0;
    endtask

    task automatic rsp(input logic [31:0] r);
        apu_rvalid_i = 1'b1;
        apu_result_i = r;
        apu_flags_i  = r[4:0];
    endtask

    // Hand-written payload each core drives (must match the initial setup below)
    task automatic push_gnt(input int c);
        gnt_exp_t e;
        e.gnt = (c == 0) ? 2'b01 : 2'b10;
        e.op  = (c == 0) ? 6'h0A : 6'h15;
        e.opa = (c == 0) ? 32'hA000_0001 : 32'hB000_0002;
        gnt_q.push_back(e);
    endtask

    task automatic push_rv(input int c, input logic [31:0] r);
        rv_exp_t e;
        e.rv  = (c == 0) ? 2'b01 : 2'b10;
        e.res = r;
        e.flg = r[4:0];
        rv_q.push_back(e);
    endtask

    // Monitor: compare every presented grant/response against the scoreboard
    always @(negedge clk_i) begin : monitor
        gnt_exp_t ge;
        rv_exp_t  re;
        if (rst_i === 1'b0) begin
            if (core_gnt_o != '0) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 64'(core_gnt_o), 64'(0));
                end else begin
                    ge = gnt_q.pop_front();
                    check("gnt", 64'(core_gnt_o), 64'(ge.gnt));
                    check("gnt_op", 64'(apu_op_o), 64'(ge.op));
                    check("gnt_operand0", 64'(apu_operands_o[0]), 64'(ge.opa));
                end
            end
            if (core_rvalid_o != '0) begin
                if (rv_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(core_rvalid_o), 64'(0));
                end else begin
                    re = rv_q.pop_front();
                    check("rvalid", 64'(core_rvalid_o), 64'(re.rv));
                    check("result", 64'(core_result_o), 64'(re.res));
                    check("rflags", 64'(core_flags_o), 64'(re.flg));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c;
        core_operands_i       = '0;
        core_operands_i[0][0] = 32'hA000_0001;
        core_operands_i[1][0] = 32'hB000_0002;
        core_op_i[0]          = 6'h0A;
        core_op_i[1]          = 6'h15;
        core_flags_i[0]       = 15'h0011;
        core_flags_i[1]       = 15'h0022;

        // Reset with every input active: nothing may leak out
        rst_i        = 1'b1;
        core_req_i   = 2'b11;
        apu_gnt_i    = 1'b1;
        apu_rvalid_i = 1'b1;
        apu_result_i = 32'h1234_5678;
        apu_flags_i  = '0;
        tick();
        tick();
        @(negedge clk_i);
        check("rst_apu_req", 64'(apu_req_o), 64'(0));
        check("rst_gnt", 64'(core_gnt_o), 64'(0));
        check("rst_rvalid", 64'(core_rvalid_o), 64'(0));
        tick();
        rst_i = 1'b0;
        idle();
        @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_stat0", 64'(stat_grant_cnt_o[0]), 64'(0));
        check("rst_stat1", 64'(stat_grant_cnt_o[1]), 64'(0));
        tick();

        // Scenario 1: both request, grants alternate, responses one cycle behind
        for (int i = 0; i < 4; i++) begin
            core_req_i = 2'b11;
            apu_gnt_i  = 1'b1;
            push_gnt(i % 2);
            if (i > 0) begin
                rsp(32'(32'h100 + i));
                push_rv((i - 1) % 2, 32'(32'h100 + i));
            end else begin
                apu_rvalid_i = 1'b0;
            end
            tick();
        end
        core_req_i = '0;
        apu_gnt_i  = 1'b0;
        rsp(32'h104);
        push_rv(1, 32'h104);
        tick();
        idle();

        // Scenario 2: core 0 fills the ID FIFO, then one response frees a slot
        for (int i = 0; i < 6; i++) begin
            core_req_i = 2'b01;
            apu_gnt_i  = 1'b1;
            if (i < 4) push_gnt(0);
            @(negedge clk_i);
            check("s2_apu_req", 64'(apu_req_o), 64'(i < 4));
            if (i == 5) check("s2_busy_full", 64'(busy_o), 64'(1));
            tick();
        end
        rsp(32'h200);
        push_rv(0, 32'h200);
        @(negedge clk_i);
        check("s2_full_with_pop", 64'(apu_req_o), 64'(0));
        tick();
        apu_rvalid_i = 1'b0;
        push_gnt(0);
        @(negedge clk_i);
        check("s2_reenabled", 64'(apu_req_o), 64'(1));
        tick();
        core_req_i = '0;
        apu_gnt_i  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rsp(32'(32'h201 + k));
            push_rv(0, 32'(32'h201 + k));
            tick();
        end
        idle();
        @(negedge clk_i);
        check("s2_drained_busy", 64'(busy_o), 64'(0));
        tick();

        // Scenario 3: rr_ptr is 1 here; outstanding IDs 1,0,1
        apu_gnt_i  = 1'b1;
        core_req_i = 2'b10; push_gnt(1); tick();
        core_req_i = 2'b01; push_gnt(0); tick();
        core_req_i = 2'b10; push_gnt(1); tick();
        core_req_i = '0;
        apu_gnt_i  = 1'b0;
        rsp(32'h3F80_0000);
        push_rv(1, 32'h3F80_0000);
        @(negedge clk_i);
        check("s3_rvalid", 64'(core_rvalid_o), 64'(2'b10));
        check("s3_result", 64'(core_result_o), 64'(32'h3F80_0000));
        tick();
        rsp(32'h301); push_rv(0, 32'h301); tick();
        rsp(32'h302); push_rv(1, 32'h302); tick();
        idle();

        // Scenario 4: spurious response on empty FIFO is dropped and sticks err_o
        @(negedge clk_i);
        check("s4_err_before", 64'(err_o), 64'(0));
        tick();
        rsp(32'hDEAD);
        @(negedge clk_i);
        check("s4_dropped", 64'(core_rvalid_o), 64'(0));
        tick();
        idle();
        check("s4_err_set", 64'(err_o), 64'(1));
        for (int k = 0; k < 10; k++) tick();
        check("s4_err_sticky", 64'(err_o), 64'(1));

        // Scenario 5: reset with 2 outstanding IDs and rr_ptr left at 1
        apu_gnt_i  = 1'b1;
        core_req_i = 2'b10; push_gnt(1); tick();
        core_req_i = 2'b01; push_gnt(0); tick();
        idle();
        check("s5_busy_pre", 64'(busy_o), 64'(1));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("s5_busy_post", 64'(busy_o), 64'(0));
        check("s5_err_cleared", 64'(err_o), 64'(0));
        tick();
        rsp(32'h500);
        @(negedge clk_i);
        check("s5_late_dropped", 64'(core_rvalid_o), 64'(0));
        tick();
        idle();
        check("s5_late_err", 64'(err_o), 64'(1));
        apu_gnt_i  = 1'b1;
        core_req_i = 2'b11; push_gnt(0); tick();
        core_req_i = 2'b10; push_gnt(1); tick();
        core_req_i = '0;
        apu_gnt_i  = 1'b0;
        rsp(32'h501); push_rv(0, 32'h501); tick();
        rsp(32'h502); push_rv(1, 32'h502); tick();
        idle();

        // Scenario 6: 5 grants to core 0 then 3 to core 1
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        c = 0;
        for (int i = 0; i < 8; i++) begin
            c = (i < 5) ? 0 : 1;
            core_req_i = (c == 0) ? 2'b01 : 2'b10;
            apu_gnt_i  = 1'b1;
            push_gnt(c);
            if (i > 0) begin
                rsp(32'(32'h600 + i));
                push_rv((i - 1 < 5) ? 0 : 1, 32'(32'h600 + i));
            end else begin
                apu_rvalid_i = 1'b0;
            end
            tick();
        end
        core_req_i = '0;
        apu_gnt_i  = 1'b0;
        rsp(32'h608);
        push_rv(1, 32'h608);
        tick();
        idle();
        @(negedge clk_i);
`ifdef CV32E40P_APU_ARB_STATS_EN
        check("s6_stat0", 64'(stat_grant_cnt_o[0]), 64'(5));
        check("s6_stat1", 64'(stat_grant_cnt_o[1]), 64'(3));
`else
        check("s6_stat0", 64'(stat_grant_cnt_o[0]), 64'(0));
        check("s6_stat1", 64'(stat_grant_cnt_o[1]), 64'(0));
`endif
        check("end_busy", 64'(busy_o), 64'(0));
        tick();
        tick();
        check("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
        check("rv_q_drained", 64'(rv_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
